// File: rtl/debounce_sync.sv
// debounce_sync: synchroniser chain + four-state debounce FSM producing a clean level y.
// Optional macro DEBOUNCE_EDGE_EN adds registered rise/fall strobes aligned with y changes.
module debounce_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic x_async,
   output logic y
`ifdef DEBOUNCE_EDGE_EN
   ,
   output logic rise,
   output logic fall
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   y_q, y_d;

   // Plain shift chain; only the last stage is allowed to feed logic.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], x_async};
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         y_q     <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   // Any sample matching y during a check restarts from scratch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      case (state_q)
         STABLE_LO: begin
            cnt_d = '0;
            if (s) state_d = CHECK_HI;
         end
         CHECK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               y_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            cnt_d = '0;
            if (!s) state_d = CHECK_LO;
         end
         CHECK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               y_d     = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   assign y = y_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Strobes are registered on the same edge that updates y.
   always_comb begin
      rise_d = y_d & ~y_q;
      fall_d = ~y_d & y_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: expected y transitions (cycle, level) are queued by the
// stimulus and consumed by a negedge monitor whenever y changes.
`timescale 1ns/1ps
module tb_debounce_sync;

   logic clk;
   logic reset;
   logic x_async;
   logic x1_async;
   logic y;
   logic y1;
`ifdef DEBOUNCE_EDGE_EN
   logic rise, fall, rise1, fall1;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [32:0] exp_q[$];
   logic [32:0] exp1_q[$];

   debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .x_async(x_async), .y(y)
`ifdef DEBOUNCE_EDGE_EN
      , .rise(rise), .fall(fall)
`endif
   );

   debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .x_async(x1_async), .y(y1)
`ifdef DEBOUNCE_EDGE_EN
      , .rise(rise1), .fall(fall1)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drive x_async at a negedge; if a y change is expected, it lands on posedge cyc+7
   task automatic drive_x(input logic v, input bit expect_change);
      x_async = v;
      if (expect_change) exp_q.push_back({v, 32'(cyc + 7)});
   endtask

   task automatic drive_x1(input logic v, input bit expect_change);
      x1_async = v;
      if (expect_change) exp1_q.push_back({v, 32'(cyc + 4)});
   endtask

   task automatic chk_fsm(input string name, input logic [1:0] st, input logic [31:0] cnt);
      logic [1:0] st_act;
      st_act = dut.state_q;
      chk({name, "_state"}, 32'(st_act), 32'(st));
      chk({name, "_cnt"}, 32'(dut.cnt_q), cnt);
   endtask

   // monitor / scoreboard
   logic y_prev  = 1'b0;
   logic y1_prev = 1'b0;
   always @(negedge clk) begin
      logic [32:0] e;
      if (y !== y_prev) begin
         if (exp_q.size() == 0) chk("y_unexpected_change", 32'(y), 32'(y_prev));
         else begin
            e = exp_q.pop_front();
            chk("y_change_cycle", 32'(cyc), e[31:0]);
            chk("y_change_value", 32'(y), 32'(e[32]));
         end
      end
`ifdef DEBOUNCE_EDGE_EN
      chk("rise_strobe", 32'(rise), 32'((y !== y_prev) && y));
      chk("fall_strobe", 32'(fall), 32'((y !== y_prev) && !y));
      chk("rise_fall_overlap", 32'(rise & fall), 0);
`endif
      y_prev = y;
      if (y1 !== y1_prev) begin
         if (exp1_q.size() == 0) chk("y1_unexpected_change", 32'(y1), 32'(y1_prev));
         else begin
            e = exp1_q.pop_front();
            chk("y1_change_cycle", 32'(cyc), e[31:0]);
            chk("y1_change_value", 32'(y1), 32'(e[32]));
         end
      end
      y1_prev = y1;
   end

   // stimulus
   initial begin
      reset    = 1'b0;
      x_async  = 1'b0;
      x1_async = 1'b0;
      #2;
      chk("reset_y", 32'(y), 0);
      chk_fsm("reset", 2'd0, 0);
      chk("reset_sync", 32'(dut.sync_q), 0);
`ifdef DEBOUNCE_EDGE_EN
      chk("reset_rise", 32'(rise), 0);
      chk("reset_fall", 32'(fall), 0);
`endif
      wait_cycles(2);
      reset = 1'b1;
      wait_cycles(3);

      // clean rise
      drive_x(1'b1, 1'b1);
      wait_cycles(12);
      chk("clean_rise_y", 32'(y), 1);
      chk_fsm("clean_rise", 2'd2, 0);

      // 4-cycle low glitch while high
      drive_x(1'b0, 1'b0);
      wait_cycles(4);
      drive_x(1'b1, 1'b0);
      wait_cycles(12);
      chk("low_glitch_y", 32'(y), 1);
      chk_fsm("low_glitch", 2'd2, 0);

      // clean fall
      drive_x(1'b0, 1'b1);
      wait_cycles(12);
      chk("clean_fall_y", 32'(y), 0);

      // 3-cycle high glitch
      drive_x(1'b1, 1'b0);
      wait_cycles(3);
      drive_x(1'b0, 1'b0);
      wait_cycles(12);
      chk("high_glitch_y", 32'(y), 0);
      chk_fsm("high_glitch", 2'd0, 0);

      // bounce every 2 cycles, then settle high
      for (int i = 0; i < 5; i++) begin
         drive_x(1'b1, 1'b0);
         wait_cycles(2);
         drive_x(1'b0, 1'b0);
         wait_cycles(2);
      end
      drive_x(1'b1, 1'b1);
      wait_cycles(12);
      chk("bounce_settle_y", 32'(y), 1);

      // toggling every cycle never moves y
      for (int i = 0; i < 16; i++) begin
         drive_x(~x_async, 1'b0);
         wait_cycles(1);
      end
      chk("fast_toggle_y", 32'(y), 1);
      drive_x(1'b0, 1'b1);
      wait_cycles(12);
      chk("fall_after_toggle_y", 32'(y), 0);

      // DEBOUNCE_CYCLES=1 instance: one sample rejected, two accepted
      drive_x1(1'b1, 1'b0);
      wait_cycles(1);
      drive_x1(1'b0, 1'b0);
      wait_cycles(8);
      chk("dc1_glitch_y1", 32'(y1), 0);
      drive_x1(1'b1, 1'b1);
      wait_cycles(8);
      chk("dc1_rise_y1", 32'(y1), 1);
      drive_x1(1'b0, 1'b1);
      wait_cycles(8);
      chk("dc1_fall_y1", 32'(y1), 0);

      // reset in CHECK_HI at cnt=2, release with x high
      drive_x(1'b1, 1'b0);
      wait_cycles(5);
      chk_fsm("pre_reset", 2'd1, 2);
      #1 reset = 1'b0;
      #1;
      chk("mid_reset_y", 32'(y), 0);
      chk_fsm("mid_reset", 2'd0, 0);
      chk("mid_reset_sync", 32'(dut.sync_q), 0);
      wait_cycles(3);
      reset = 1'b1;
      exp_q.push_back({1'b1, 32'(cyc + 7)});
      wait_cycles(12);
      chk("post_reset_rise_y", 32'(y), 1);

      chk("exp_q_drained", 32'(exp_q.size()), 0);
      chk("exp1_q_drained", 32'(exp1_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
